// File: rtl/alu16_pkg.sv
// Shared constants and helpers for the 16-bit execute-stage ALU.
// Opcodes, datapath widths and the 4-bit ripple block used by the carry-select adder.
package alu16_pkg;

    localparam int DATA_W = 16;
    localparam int BLK_W  = 4;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_OR  = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_SHR = 3'b111;

    // Bit-serial ripple sum of one block; returns {carry_out, sum}.
    function automatic logic [BLK_W:0] ripple_add(input logic [BLK_W-1:0] a,
                                                  input logic [BLK_W-1:0] b,
                                                  input logic             cin);
        logic             c;
        logic [BLK_W-1:0] s;
        c = cin;
        s = '0;
        for (int i = 0; i < BLK_W; i++) begin
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        return {c, s};
    endfunction

endpackage

// File: rtl/csla_adder_16.sv
// 16-bit carry-select adder: ripple low nibble, upper three nibbles precomputed
// for both carry-in values and selected by the carry from the block below.
module csla_adder_16
    import alu16_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              cin,
    output logic [DATA_W-1:0] sum,
    output logic              cout
);

    logic [BLK_W:0] blk0_s;
    logic [BLK_W:0] blk1_c0_s, blk1_c1_s, blk1_s;
    logic [BLK_W:0] blk2_c0_s, blk2_c1_s, blk2_s;
    logic [BLK_W:0] blk3_c0_s, blk3_c1_s, blk3_s;

    assign blk0_s    = ripple_add(a[3:0], b[3:0], cin);

    assign blk1_c0_s = ripple_add(a[7:4], b[7:4], 1'b0);
    assign blk1_c1_s = ripple_add(a[7:4], b[7:4], 1'b1);
    assign blk1_s    = blk0_s[BLK_W] ? blk1_c1_s : blk1_c0_s;

    assign blk2_c0_s = ripple_add(a[11:8], b[11:8], 1'b0);
    assign blk2_c1_s = ripple_add(a[11:8], b[11:8], 1'b1);
    assign blk2_s    = blk1_s[BLK_W] ? blk2_c1_s : blk2_c0_s;

    assign blk3_c0_s = ripple_add(a[15:12], b[15:12], 1'b0);
    assign blk3_c1_s = ripple_add(a[15:12], b[15:12], 1'b1);
    assign blk3_s    = blk2_s[BLK_W] ? blk3_c1_s : blk3_c0_s;

    assign sum  = {blk3_s[3:0], blk2_s[3:0], blk1_s[3:0], blk0_s[3:0]};
    assign cout = blk3_s[BLK_W];

endmodule

// File: rtl/alu_16bit.sv
// Registered 16-bit ALU (add/sub via CSLA, logic ops, 1-bit shifts), one-cycle latency.
// Optional registered Zero flag output when ALU16_ZERO_FLAG_EN is defined.
module alu_16bit
    import alu16_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic [2:0]        opcode,
    input  logic              Enable,
    output logic [DATA_W-1:0] result,
    output logic              Cout
`ifdef ALU16_ZERO_FLAG_EN
    ,
    output logic              Zero
`endif
);

    logic [DATA_W-1:0] add_b_s;
    logic              add_cin_s;
    logic [DATA_W-1:0] add_sum_s;
    logic              add_cout_s;
    logic [DATA_W-1:0] result_d, result_q;
    logic              cout_d, cout_q;

    // SUB reuses the adder as A + ~B + 1, so Cout is the no-borrow flag.
    assign add_b_s   = (opcode == OP_SUB) ? ~B : B;
    assign add_cin_s = (opcode == OP_SUB) ? 1'b1 : 1'b0;

    csla_adder_16 u_csla (
        .a    (A),
        .b    (add_b_s),
        .cin  (add_cin_s),
        .sum  (add_sum_s),
        .cout (add_cout_s)
    );

    // Opcode decode into next result and carry.
    always_comb begin
        result_d = 16'h0000;
        cout_d   = 1'b0;
        case (opcode)
            OP_ADD, OP_SUB: begin
                result_d = add_sum_s;
                cout_d   = add_cout_s;
            end
            OP_OR:  result_d = A | B;
            OP_AND: result_d = A & B;
            OP_XOR: result_d = A ^ B;
            OP_NOT: result_d = ~A;
            OP_SHL: begin
                result_d = {A[14:0], 1'b0};
                cout_d   = A[15];
            end
            OP_SHR: begin
                result_d = {1'b0, A[15:1]};
                cout_d   = A[0];
            end
            default: begin
                result_d = 16'h0000;
                cout_d   = 1'b0;
            end
        endcase
    end

    // Output register: reset wins over Enable; hold when disabled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result_q <= 16'h0000;
            cout_q   <= 1'b0;
        end else if (Enable) begin
            result_q <= result_d;
            cout_q   <= cout_d;
        end else begin
            result_q <= result_q;
            cout_q   <= cout_q;
        end
    end

    assign result = result_q;
    assign Cout   = cout_q;

`ifdef ALU16_ZERO_FLAG_EN
    logic zero_d, zero_q;

    assign zero_d = (result_d == 16'h0000);

    // Zero flag register, tracks the result register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            zero_q <= 1'b0;
        end else if (Enable) begin
            zero_q <= zero_d;
        end else begin
            zero_q <= zero_q;
        end
    end

    assign Zero = zero_q;
`endif

endmodule

// File: tb/tb_alu_16bit.sv
// Scoreboard testbench for alu_16bit: expected outputs are queued when stimulus is
// driven and compared one cycle later; covers directed cases, hold/reset and random traffic.
module tb_alu_16bit;

    logic        clk;
    logic        rst_n;
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  opcode;
    logic        enable;
    logic [15:0] result;
    logic        cout;
    logic        zero;

    int errors = 0;
    int checks = 0;

    // {zero, cout, result} expected after the next rising edge
    logic [17:0] sb_q[$];
    logic [17:0] model_state;
    logic [17:0] exp_v;

    alu_16bit dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .A      (a),
        .B      (b),
        .opcode (opcode),
        .Enable (enable),
        .result (result),
        .Cout   (cout)
`ifdef ALU16_ZERO_FLAG_EN
        ,
        .Zero   (zero)
`endif
    );

`ifndef ALU16_ZERO_FLAG_EN
    assign zero = 1'bx;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [16:0] ref_op(input logic [15:0] x, input logic [15:0] y,
                                           input logic [2:0] op);
        logic [16:0] r;
        case (op)
            3'd0: r = {1'b0, x} + {1'b0, y};
            3'd1: r = {(x >= y), 16'(x - y)};
            3'd2: r = {1'b0, x | y};
            3'd3: r = {1'b0, x & y};
            3'd4: r = {1'b0, x ^ y};
            3'd5: r = {1'b0, ~x};
            3'd6: r = {x[15], x << 1};
            default: r = {x[0], x >> 1};
        endcase
        return r;
    endfunction

    // Drive one cycle at the falling edge, queue the expectation, sample #1 after the rising edge.
    task automatic drive_cycle(input logic [15:0] x, input logic [15:0] y,
                               input logic [2:0] op, input logic en, input logic rn);
        logic [16:0] r;
        @(negedge clk);
        a = x; b = y; opcode = op; enable = en; rst_n = rn;
        r = ref_op(x, y, op);
        if (!rn)     model_state = 18'd0;
        else if (en) model_state = {(r[15:0] == 16'h0000), r};
        sb_q.push_back(model_state);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive_cycle(16'h1234, 16'h4321, 3'd0, 1'b1, 1'b0);
        exp_v = sb_q.pop_front();
        checks++;
        if (result !== 16'h0000 || cout !== 1'b0 || result !== exp_v[15:0]) begin
            errors++;
            $display("FAIL reset: result=%h cout=%b, want 0000/0", result, cout);
        end
`ifdef ALU16_ZERO_FLAG_EN
        checks++;
        if (zero !== 1'b0) begin
            errors++;
            $display("FAIL reset_zero: zero=%b, want 0", zero);
        end
`endif
    endtask

    task automatic test_directed();
        logic [15:0] da[12] = '{16'h0005, 16'hFFFF, 16'h0008, 16'h0003, 16'h00F0, 16'h00F0,
                                16'hAAAA, 16'h0F0F, 16'h0001, 16'h8000, 16'h8000, 16'h0000};
        logic [15:0] db[12] = '{16'h0003, 16'h0001, 16'h0003, 16'h0008, 16'h0F0F, 16'h0F0F,
                                16'h5555, 16'h1234, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        logic [2:0]  dop[12] = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd3,
                                 3'd4, 3'd5, 3'd6, 3'd6, 3'd7, 3'd0};
        logic [16:0] dexp[12] = '{17'h00008, 17'h10000, 17'h10005, 17'h0FFFB, 17'h00FFF, 17'h00000,
                                  17'h0FFFF, 17'h0F0F0, 17'h00002, 17'h10000, 17'h04000, 17'h00000};
        for (int i = 0; i < 12; i++) begin
            drive_cycle(da[i], db[i], dop[i], 1'b1, 1'b1);
            exp_v = sb_q.pop_front();
            checks++;
            if ({cout, result} !== dexp[i] || {cout, result} !== exp_v[16:0]) begin
                errors++;
                $display("FAIL directed[%0d]: got cout=%b result=%h, want cout=%b result=%h",
                         i, cout, result, dexp[i][16], dexp[i][15:0]);
            end
        end
    endtask

    task automatic test_enable_hold();
        drive_cycle(16'h0005, 16'h0003, 3'd0, 1'b1, 1'b1);
        exp_v = sb_q.pop_front();
        for (int i = 0; i < 3; i++) begin
            drive_cycle(16'hFFFF + 16'(i), 16'h7777, 3'(i), 1'b0, 1'b1);
            exp_v = sb_q.pop_front();
            checks++;
            if (result !== 16'h0008 || cout !== 1'b0 || result !== exp_v[15:0]) begin
                errors++;
                $display("FAIL hold[%0d]: result=%h cout=%b, want 0008/0", i, result, cout);
            end
        end
        drive_cycle(16'hFFFF, 16'h0001, 3'd0, 1'b1, 1'b0);
        exp_v = sb_q.pop_front();
        checks++;
        if (result !== 16'h0000 || cout !== 1'b0) begin
            errors++;
            $display("FAIL reset_priority: result=%h cout=%b, want 0000/0", result, cout);
        end
    endtask

    task automatic test_carry_boundaries();
        logic [15:0] ba[4] = '{16'h000F, 16'h00FF, 16'h0FFF, 16'hFFF0};
        logic [16:0] bexp[4] = '{17'h00010, 17'h00100, 17'h01000, 17'h0FFF1};
        for (int i = 0; i < 4; i++) begin
            drive_cycle(ba[i], 16'h0001, 3'd0, 1'b1, 1'b1);
            exp_v = sb_q.pop_front();
            checks++;
            if ({cout, result} !== bexp[i]) begin
                errors++;
                $display("FAIL carry_boundary[%0d]: got %b/%h, want %b/%h",
                         i, cout, result, bexp[i][16], bexp[i][15:0]);
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] x, y;
        for (int i = 0; i < 10000; i++) begin
            x = 16'($urandom);
            y = 16'($urandom);
            if ((i % 16) == 0) begin
                x = (i % 48 == 0) ? 16'h000F : ((i % 48 == 16) ? 16'h00FF : 16'h0FFF);
                y = 16'h0001;
            end
            drive_cycle(x, y, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'b1);
            exp_v = sb_q.pop_front();
            checks++;
            if (result !== exp_v[15:0] || cout !== exp_v[16]) begin
                errors++;
                $display("FAIL random[%0d]: got %b/%h, want %b/%h",
                         i, cout, result, exp_v[16], exp_v[15:0]);
            end
`ifdef ALU16_ZERO_FLAG_EN
            checks++;
            if (zero !== exp_v[17]) begin
                errors++;
                $display("FAIL random_zero[%0d]: got %b, want %b", i, zero, exp_v[17]);
            end
`endif
        end
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; a = 16'h0000; b = 16'h0000; opcode = 3'd0;
        model_state = 18'd0;
        test_reset();
        test_directed();
        test_enable_hold();
        test_carry_boundaries();
        test_random();
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d left, want 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
